// File: rtl/an_encoder_seq.sv
// AN-code encoder: serial shift-add multiply of in_data by A, optional +/-2^pos error.
// Ports: clk, rst_n, in_valid/in_ready/in_data, inj_en/inj_sub/inj_pos, out_valid/out_ready/out_code/out_clean.
module an_encoder_seq #(
  parameter int A = 19,
  parameter int N = 4,
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         inj_en,
  input  logic         inj_sub,
  input  logic [3:0]   inj_pos,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_code,
  output logic [W-1:0] out_clean
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] AW = W'(A);
  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t state_q, state_d;
  logic [W-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0] data_q, data_d;
  logic inj_en_q, inj_en_d;
  logic inj_sub_q, inj_sub_d;
  logic [3:0] inj_pos_q, inj_pos_d;
  logic [W-1:0] code_q, code_d;
  logic [W-1:0] clean_q, clean_d;

  logic [W-1:0] add;
  logic [W-1:0] sum;
  logic [W-1:0] err;
  logic [W-1:0] inj_val;
  logic pos_ok;

  assign add = data_q[cnt_q] ? (AW << cnt_q) : '0;
  assign sum = acc_q + add;
  // Error positions past the codeword width are dropped.
  assign pos_ok = 32'(inj_pos_q) < W;
  assign err = pos_ok ? (ONE << inj_pos_q) : '0;
  assign inj_val = !inj_en_q ? sum :
                   inj_sub_q ? sum - err : sum + err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      inj_en_q  <= 1'b0;
      inj_sub_q <= 1'b0;
      inj_pos_q <= '0;
      code_q    <= '0;
      clean_q   <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      inj_en_q  <= inj_en_d;
      inj_sub_q <= inj_sub_d;
      inj_pos_q <= inj_pos_d;
      code_q    <= code_d;
      clean_q   <= clean_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    inj_en_d  = inj_en_q;
    inj_sub_d = inj_sub_q;
    inj_pos_d = inj_pos_q;
    code_d    = code_q;
    clean_d   = clean_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d    = in_data;
          inj_en_d  = inj_en;
          inj_sub_d = inj_sub;
          inj_pos_d = inj_pos;
          acc_d     = '0;
          cnt_d     = '0;
          state_d   = MUL;
        end
      end
      MUL: begin
        acc_d = sum;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          clean_d = sum;
          code_d  = inj_val;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_code  = code_q;
  assign out_clean = clean_q;

endmodule

// File: tb/tb_an_encoder_seq.sv
// Bench for an_encoder_seq (A=19, N=4, W=9): vector table, scoreboard,
// stall, back-to-back and mid-flight reset sequences.
module tb_an_encoder_seq;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic in_ready;
  logic [3:0] in_data;
  logic inj_en;
  logic inj_sub;
  logic [3:0] inj_pos;
  logic out_valid;
  logic out_ready;
  logic [8:0] out_code;
  logic [8:0] out_clean;

  an_encoder_seq #(.A(19), .N(4), .W(9)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .inj_en(inj_en),
    .inj_sub(inj_sub),
    .inj_pos(inj_pos),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_code(out_code),
    .out_clean(out_clean)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d;
    logic en;
    logic sub;
    logic [3:0] pos;
    logic [8:0] code;
    logic [8:0] clean;
  } vec_t;

  typedef struct {
    logic [8:0] code;
    logic [8:0] clean;
    int acc_cyc;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic ov_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && in_ready)
        chk("ready_and_valid", 32'(in_ready), 0);
      if (out_valid && !ov_prev) begin
        if (sb.size() == 0)
          chk("unexpected_valid", 32'(out_valid), 0);
        else
          chk("latency", 32'(cyc - sb[0].acc_cyc), 4);
      end
      if (out_valid && out_ready && sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("out_code", 32'(out_code), 32'(e.code));
        chk("out_clean", 32'(out_clean), 32'(e.clean));
        chk("clean_mod_a", 32'(out_clean) % 19, 0);
      end
    end
    ov_prev = out_valid;
  end

  task automatic send(input logic [3:0] d, input logic en, input logic sub,
                      input logic [3:0] pos, input logic [8:0] code,
                      input logic [8:0] clean);
    int n;
    in_data  = d;
    inj_en   = en;
    inj_sub  = sub;
    inj_pos  = pos;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 1);
    else sb.push_back('{code, clean, cyc + 1});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sb.size()), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{4'd5,  1'b0, 1'b0, 4'd0,  9'd95,  9'd95};
    vecs[1]  = '{4'd15, 1'b0, 1'b0, 4'd0,  9'd285, 9'd285};
    vecs[2]  = '{4'd0,  1'b0, 1'b0, 4'd0,  9'd0,   9'd0};
    vecs[3]  = '{4'd7,  1'b1, 1'b0, 4'd3,  9'd141, 9'd133};
    vecs[4]  = '{4'd0,  1'b1, 1'b1, 4'd0,  9'd511, 9'd0};
    vecs[5]  = '{4'd9,  1'b1, 1'b0, 4'd12, 9'd171, 9'd171};
    vecs[6]  = '{4'd3,  1'b1, 1'b1, 4'd2,  9'd53,  9'd57};
    vecs[7]  = '{4'd15, 1'b1, 1'b0, 4'd8,  9'd29,  9'd285};
    vecs[8]  = '{4'd1,  1'b1, 1'b1, 4'd5,  9'd499, 9'd19};
    vecs[9]  = '{4'd10, 1'b0, 1'b0, 4'd0,  9'd190, 9'd190};
    vecs[10] = '{4'd12, 1'b0, 1'b1, 4'd1,  9'd228, 9'd228};
    vecs[11] = '{4'd6,  1'b1, 1'b0, 4'd15, 9'd114, 9'd114};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    inj_en = 1'b0;
    inj_sub = 1'b0;
    inj_pos = '0;
    out_ready = 1'b1;
    #12;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_code", 32'(out_code), 0);
    chk("rst_out_clean", 32'(out_clean), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++)
      send(vecs[i].d, vecs[i].en, vecs[i].sub, vecs[i].pos,
           vecs[i].code, vecs[i].clean);
    drain();

    // Stall in DONE with in_valid high and in_data toggling.
    out_ready = 1'b0;
    send(4'd13, 1'b0, 1'b0, 4'd0, 9'd247, 9'd247);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("stall_valid", 32'(out_valid), 1);
    end
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      in_data = 4'(k * 5 + 1);
      @(negedge clk);
      chk("stall_code", 32'(out_code), 247);
      chk("stall_in_ready", 32'(in_ready), 0);
      chk("stall_out_valid", 32'(out_valid), 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_data = 4'd2;
    @(negedge clk);
    sb.push_back('{9'd38, 9'd38, cyc + 2});
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("ready_after_hs", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();

    // Reset during MUL cycle 2 discards the word in flight.
    send(4'd11, 1'b0, 1'b0, 4'd0, 9'd209, 9'd209);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_code", 32'(out_code), 0);
    chk("midrst_clean", 32'(out_clean), 0);
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_ready", 32'(in_ready), 1);
    sb.delete();
    in_data = 4'd3;
    inj_en = 1'b0;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back('{9'd57, 9'd57, cyc + 1});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
